// File: rtl/scoreboard_pkg.sv
// Shared types for the ID->EX issue scoreboard: FSM states and pending-write counter type.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    SB_RUN     = 2'd0,
    SB_DRAIN   = 2'd1,
    SB_DRAINED = 2'd2
  } sb_state_t;

  typedef logic [1:0] pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = 2'd3;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters with increment/decrement ports and zero/full flags.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- a register whose last pending write retires
// this cycle is reported as free for source reads in the same cycle.
module sb_counter_bank
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clr,
  input  logic                  i_inc_en,
  input  logic [REG_ADDR_W-1:0] i_inc_addr,
  input  logic                  i_dec_en,
  input  logic [REG_ADDR_W-1:0] i_dec_addr,
  output logic [NUM_REGS-1:0]   o_zero,
  output logic [NUM_REGS-1:0]   o_full,
  output logic [NUM_REGS-1:0]   o_src_free
);

  pend_cnt_t           r_pend [NUM_REGS];
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;

  // Decode the increment/decrement addresses; x0 is never incremented.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_inc[i] = i_inc_en && (i_inc_addr == REG_ADDR_W'(i));
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      w_dec[i] = i_dec_en && (i_dec_addr == REG_ADDR_W'(i));
    end
  end

  // Counter update: simultaneous inc and dec of the same register cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_pend[i] != PEND_MAX)) begin
          r_pend[i] <= r_pend[i] + 2'd1;
        end else if (w_dec[i] && !w_inc[i] && (r_pend[i] != 2'd0)) begin
          r_pend[i] <= r_pend[i] - 2'd1;
        end
      end
    end
  end

  // Status flags; source-free optionally includes a register retiring its last pending write.
  always_comb begin
    o_zero     = '0;
    o_full     = '0;
    o_src_free = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_zero[i] = (r_pend[i] == 2'd0);
      o_full[i] = (r_pend[i] == PEND_MAX);
`ifdef SCOREBOARD_BYPASS_EN
      o_src_free[i] = (r_pend[i] == 2'd0) || (w_dec[i] && (r_pend[i] == 2'd1));
`else
      o_src_free[i] = (r_pend[i] == 2'd0);
`endif
    end
  end

endmodule

// File: rtl/ex_issue_scoreboard.sv
// ID->EX issue scoreboard: RAW/WAW hazard stall, in-flight limit, drain sequencing, stall counter.
// Optional feature macro: SCOREBOARD_BYPASS_EN (same-cycle retire frees a source, see sb_counter_bank).
module ex_issue_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_INFLIGHT = 3,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr,
  input  logic                   id_rs1_used,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr,
  input  logic                   id_rs2_used,
  input  logic [REG_ADDR_W-1:0]  id_rd_addr,
  input  logic                   id_rd_wr_en,
  input  logic                   wb_wr_en,
  input  logic [REG_ADDR_W-1:0]  wb_wr_addr,
  input  logic                   flush,
  input  logic                   drain_req,
  output logic                   drained,
  output logic [2:0]             inflight_cnt,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   sb_error
);

  sb_state_t              r_state;
  logic                   r_drained;
  logic [2:0]             r_inflight;
  logic [STALL_CNT_W-1:0] r_stall;
  logic                   r_err;

  logic [NUM_REGS-1:0]    w_zero;
  logic [NUM_REGS-1:0]    w_full;
  logic [NUM_REGS-1:0]    w_src_free;
  logic                   w_hazard;
  logic                   w_issue;
  logic                   w_ret_ok;
  logic                   w_ret_err;

  sb_counter_bank #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_bank (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clr      (flush),
    .i_inc_en   (w_issue && id_rd_wr_en),
    .i_inc_addr (id_rd_addr),
    .i_dec_en   (w_ret_ok),
    .i_dec_addr (wb_wr_addr),
    .o_zero     (w_zero),
    .o_full     (w_full),
    .o_src_free (w_src_free)
  );

  // Hazard, handshake and retire classification. A retire is legal only if something is in
  // flight and, for a real register, that register has a pending write. Flush overrides both.
  always_comb begin
    w_hazard  = (id_rs1_used && !w_src_free[id_rs1_addr]) ||
                (id_rs2_used && !w_src_free[id_rs2_addr]) ||
                (id_rd_wr_en && (id_rd_addr != '0) && w_full[id_rd_addr]);
    id_ready  = (r_state == SB_RUN) && !w_hazard && (r_inflight < 3'(MAX_INFLIGHT));
    w_issue   = id_valid && id_ready && !flush;
    w_ret_ok  = wb_wr_en && !flush && (r_inflight != 3'd0) &&
                ((wb_wr_addr == '0) || !w_zero[wb_wr_addr]);
    w_ret_err = wb_wr_en && !flush && !w_ret_ok;
  end

  // In-flight count, sticky retire error and saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
      r_stall    <= '0;
    end else begin
      if (flush) begin
        r_inflight <= '0;
      end else if (w_issue && !w_ret_ok) begin
        r_inflight <= r_inflight + 3'd1;
      end else if (w_ret_ok && !w_issue) begin
        r_inflight <= r_inflight - 3'd1;
      end
      if (w_ret_err) r_err <= 1'b1;
      if (id_valid && !id_ready && (r_stall != {STALL_CNT_W{1'b1}})) begin
        r_stall <= r_stall + 1'b1;
      end
    end
  end

  // Drain FSM: stop issuing on request, report drained once nothing is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SB_RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        SB_RUN: begin
          if (drain_req) r_state <= SB_DRAIN;
        end
        SB_DRAIN: begin
          if (!drain_req) begin
            r_state <= SB_RUN;
          end else if (r_inflight == 3'd0) begin
            r_state   <= SB_DRAINED;
            r_drained <= 1'b1;
          end
        end
        SB_DRAINED: begin
          if (!drain_req) begin
            r_state   <= SB_RUN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= SB_RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

  assign drained      = r_drained;
  assign inflight_cnt = r_inflight;
  assign stall_cycles = r_stall;
  assign sb_error     = r_err;

endmodule

// File: tb/tb_ex_issue_scoreboard.sv
// Bench for ex_issue_scoreboard: directed vector table, hand sequences, randomized model check.
module tb_ex_issue_scoreboard;

  localparam int MAXI = 4;
  localparam int SW   = 4;
`ifdef SCOREBOARD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic          clk;
  logic          reset_n;
  logic          id_valid;
  logic          id_ready;
  logic [4:0]    id_rs1_addr;
  logic          id_rs1_used;
  logic [4:0]    id_rs2_addr;
  logic          id_rs2_used;
  logic [4:0]    id_rd_addr;
  logic          id_rd_wr_en;
  logic          wb_wr_en;
  logic [4:0]    wb_wr_addr;
  logic          flush;
  logic          drain_req;
  logic          drained;
  logic [2:0]    inflight_cnt;
  logic [SW-1:0] stall_cycles;
  logic          sb_error;

  ex_issue_scoreboard #(
    .NUM_REGS(32), .REG_ADDR_W(5), .MAX_INFLIGHT(MAXI), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_wr_en(id_rd_wr_en),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .flush(flush),
    .drain_req(drain_req), .drained(drained), .inflight_cnt(inflight_cnt),
    .stall_cycles(stall_cycles), .sb_error(sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr;
    int e_rdy, e_infl, e_drn, e_err, e_stall;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr,
                     input int rdy, infl, drn, err, stall);
    vec_t t;
    t = '{v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr, rdy, infl, drn, err, stall};
    tv.push_back(t);
  endtask

  task automatic drive(input int v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr);
    id_valid    = (v != 0);
    id_rs1_addr = 5'(rs1);
    id_rs1_used = (u1 != 0);
    id_rs2_addr = 5'(rs2);
    id_rs2_used = (u2 != 0);
    id_rd_addr  = 5'(rd);
    id_rd_wr_en = (wr != 0);
    wb_wr_en    = (wbe != 0);
    wb_wr_addr  = 5'(wba);
    flush       = (fl != 0);
    drain_req   = (dr != 0);
  endtask

  // reference model state
  int mp[32];
  int minfl, mnw, merr, mstall, mst;
  int cand[$];

  function automatic int src_busy(input int rs, input int used, input int wbe, input int wba);
    if (used == 0 || mp[rs] == 0) return 0;
    if (BYP != 0 && wbe != 0 && wba == rs && mp[rs] == 1) return 0;
    return 1;
  endfunction

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_ready", int'(id_ready), 1);
    chk("reset_inflight", int'(inflight_cnt), 0);
    chk("reset_stall", int'(stall_cycles), 0);
    chk("reset_err", int'(sb_error), 0);
    chk("reset_drained", int'(drained), 0);

    //   v rs1 u1 rs2 u2 rd wr wbe wba fl dr | rdy infl drn err stall
    add(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 1, 0, 0, 1);
    add(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0,  1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0,  1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0,  1, 2, 0, 0, 1);
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,  1, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0,  0, 4, 0, 0, 1);
    add(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0,  0, 4, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  0, 4, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,  1, 3, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0,  1, 2, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0,  1, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 2, 0, 0, 3);
    add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  0, 3, 0, 0, 3);
    add(1, 0, 0, 0, 0, 7, 1, 1, 7, 0, 0,  0, 3, 0, 0, 4);
    add(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0,  1, 2, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  1, 3, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  1, 2, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,  1, 1, 0, 0, 5);
    add(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0,  1, 0, 0, 0, 5);
    add(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 0,  1, 1, 0, 0, 5);
    add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0,  1, 1, 0, 0, 6);
    add(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 6);
    add(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1, 0, 0, 0, 6);
    add(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0, 1, 1, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 0, 0, 6);
    add(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1, 0, 2, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 1, 0, 2, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 1, 0, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 7);
    add(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1, 0, 0, 1, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0,  1, 0, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 8);
    add(1, 0, 0, 0, 0, 13, 1, 0, 0, 0, 0, 1, 0, 0, 1, 8);
    add(1, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 1, 1, 0, 1, 8);
    add(1, 0, 0, 0, 0, 15, 1, 1, 13, 1, 0, 1, 2, 0, 1, 8);
    add(1, 14, 1, 13, 1, 15, 1, 0, 0, 0, 0, 1, 0, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 1, 1, 0, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 8);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].v, tv[i].rs1, tv[i].u1, tv[i].rs2, tv[i].u2, tv[i].rd, tv[i].wr,
            tv[i].wbe, tv[i].wba, tv[i].fl, tv[i].dr);
      #1;
      chk($sformatf("vec%0d_ready", i), int'(id_ready), tv[i].e_rdy);
      chk($sformatf("vec%0d_inflight", i), int'(inflight_cnt), tv[i].e_infl);
      chk($sformatf("vec%0d_drained", i), int'(drained), tv[i].e_drn);
      chk($sformatf("vec%0d_err", i), int'(sb_error), tv[i].e_err);
      chk($sformatf("vec%0d_stall", i), int'(stall_cycles), tv[i].e_stall);
    end

    // same-cycle retire of the last pending write of a source
    @(negedge clk); drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    @(negedge clk); drive(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0);
    #1 chk("bypass_ready", int'(id_ready), BYP);
    @(negedge clk); drive(0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("after_retire_ready", int'(id_ready), 1);
    chk("after_retire_inflight", int'(inflight_cnt), BYP);

    // reset in the middle of a drain
    @(negedge clk); drive(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0);
    @(negedge clk); drive(1, 0, 0, 0, 0, 21, 1, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 chk("drain_ready", int'(id_ready), 0);
    chk("drain_inflight", int'(inflight_cnt), 2 + BYP);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_inflight", int'(inflight_cnt), 0);
    chk("midreset_err", int'(sb_error), 0);
    chk("midreset_stall", int'(stall_cycles), 0);
    chk("midreset_drained", int'(drained), 0);
    chk("midreset_ready", int'(id_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 20, 1, 21, 1, 0, 0, 0, 0, 0, 0);
    #1 chk("postreset_pend_clear", int'(id_ready), 1);

    // randomized run against the reference model
    for (int r = 0; r < 32; r++) mp[r] = 0;
    minfl = 0; mnw = 0; merr = 0; mstall = 0; mst = 0;
    begin
      int v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr, haz, rdy, ok, old_infl;
      dr = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        v   = ($urandom_range(0, 9) < 6) ? 1 : 0;
        rs1 = $urandom_range(0, 7);  u1 = $urandom_range(0, 1);
        rs2 = $urandom_range(0, 7);  u2 = $urandom_range(0, 1);
        rd  = $urandom_range(0, 7);  wr = ($urandom_range(0, 3) != 0) ? 1 : 0;
        fl  = ($urandom_range(0, 49) == 0) ? 1 : 0;
        if ($urandom_range(0, 29) == 0) dr = 1 - dr;
        wbe = 0; wba = 0;
        if ($urandom_range(0, 9) < 4) begin
          cand.delete();
          for (int r = 1; r < 32; r++) if (mp[r] > 0) cand.push_back(r);
          if (mnw > 0) cand.push_back(0);
          if (cand.size() > 0) begin
            wbe = 1;
            wba = cand[$urandom_range(0, cand.size() - 1)];
          end
        end else if ($urandom_range(0, 39) == 0) begin
          wbe = 1;
          wba = $urandom_range(16, 31);
        end
        drive(v, rs1, u1, rs2, u2, rd, wr, wbe, wba, fl, dr);
        #1;
        haz = src_busy(rs1, u1, wbe, wba) | src_busy(rs2, u2, wbe, wba) |
              ((wr != 0 && rd != 0 && mp[rd] == 3) ? 1 : 0);
        rdy = (mst == 0 && haz == 0 && minfl < MAXI) ? 1 : 0;
        chk("rnd_ready", int'(id_ready), rdy);
        chk("rnd_inflight", int'(inflight_cnt), minfl);
        chk("rnd_drained", int'(drained), (mst == 2) ? 1 : 0);
        chk("rnd_err", int'(sb_error), merr);
        chk("rnd_stall", int'(stall_cycles), mstall);
        // model update for this edge
        old_infl = minfl;
        if (v != 0 && rdy == 0 && mstall < (1 << SW) - 1) mstall++;
        if (fl != 0) begin
          for (int r = 0; r < 32; r++) mp[r] = 0;
          minfl = 0; mnw = 0;
        end else begin
          if (wbe != 0) begin
            ok = (minfl > 0 && (wba == 0 || mp[wba] > 0)) ? 1 : 0;
            if (ok != 0) begin
              minfl--;
              if (wba != 0) mp[wba]--; else mnw--;
            end else begin
              merr = 1;
            end
          end
          if (v != 0 && rdy != 0) begin
            minfl++;
            if (wr != 0 && rd != 0) mp[rd]++; else mnw++;
          end
        end
        case (mst)
          0: if (dr != 0) mst = 1;
          1: if (dr == 0) mst = 0; else if (old_infl == 0) mst = 2;
          default: if (dr == 0) mst = 0;
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
